// File: rtl/adex_spike_isi_monitor.sv
// adex_spike_isi_monitor
// Measures inter-spike intervals of the AdEx core in enabled clock cycles.
// The intervals go into a small FIFO, and the head word is streamed out
// MSB nibble first. An external master paces the stream with rising edges
// on rd_ack.
//
// state | meaning
// IDLE  | no word on the port; load the FIFO head as soon as one exists
// SEND  | latched head word is shown one nibble at a time; final ack pops it
`timescale 1ns/1ps
module adex_spike_isi_monitor #(
  parameter int TS_W       = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_core,
  input  logic                          spike_in,
  input  logic                          rd_ack,
  output logic [3:0]                    nib_out,
  output logic                          nib_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    spike_count
);

  localparam int NIBS = TS_W / 4;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int IW   = (NIBS > 1) ? $clog2(NIBS) : 1;

  localparam logic [TS_W-1:0] ISI_MAX  = '1;
  localparam logic [AW:0]     LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0]   IDX_TOP  = IW'(NIBS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state;
  logic                      spike_prev;
  logic                      ack_prev;
  logic [TS_W-1:0]           isi_cnt;
  logic [NIBS-1:0][3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [NIBS-1:0][3:0]      shreg;
  logic [IW-1:0]             nib_idx;

  logic spike_ev;
  logic ack_ev;
  logic pop;
  logic full;
  logic push_ok;

  // Event detection and FIFO handshake decisions for this cycle.
  always_comb begin
    spike_ev = spike_in & ~spike_prev & enable_core;
    ack_ev   = rd_ack & ~ack_prev;
    pop      = (state == SEND) && ack_ev && (nib_idx == '0);
    full     = (fifo_level == LVL_FULL);
    // A pop in the same cycle frees the slot the push needs, even when full.
    push_ok  = spike_ev && (!full || pop);
  end

  // Input history for edge detection; tracked whether or not the core runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      spike_prev <= 1'b0;
      ack_prev   <= 1'b0;
    end else begin
      spike_prev <= spike_in;
      ack_prev   <= rd_ack;
    end
  end

  // Interval counter: counts enabled cycles, restarts at 1 on each spike, saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      isi_cnt <= '0;
    end else if (enable_core) begin
      if (spike_ev) begin
        isi_cnt <= TS_W'(1);
      end else if (isi_cnt != ISI_MAX) begin
        isi_cnt <= isi_cnt + 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= isi_cnt;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky drop flag and saturating spike tally (dropped spikes still count).
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow    <= 1'b0;
      spike_count <= '0;
    end else if (spike_ev) begin
      if (full && !pop) begin
        overflow <= 1'b1;
      end
      if (spike_count != 8'hFF) begin
        spike_count <= spike_count + 1'b1;
      end
    end
  end

  // Serializer: latch the head word, walk nibbles down on each ack edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      nib_idx   <= '0;
      nib_out   <= 4'h0;
      nib_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          nib_valid <= 1'b0;
          if (fifo_level != '0) begin
            shreg     <= mem[rd_ptr];
            nib_idx   <= IDX_TOP;
            nib_out   <= mem[rd_ptr][IDX_TOP];
            nib_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (ack_ev) begin
            if (nib_idx != '0) begin
              nib_idx <= nib_idx - 1'b1;
              nib_out <= shreg[nib_idx - 1'b1];
            end else begin
              nib_out   <= 4'h0;
              nib_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          nib_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adex_spike_isi_monitor.sv
// Testbench for adex_spike_isi_monitor: directed scenarios plus a random
// phase, all checked against a timestamp/queue reference model.
`timescale 1ns/1ps
module tb_adex_spike_isi_monitor;

  localparam int TS_W       = 12;
  localparam int FIFO_DEPTH = 4;
  localparam int NIBS       = TS_W / 4;
  localparam int ISI_CAP    = (1 << TS_W) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable_core = 1'b0;
  logic       spike_in = 1'b0;
  logic       rd_ack = 1'b0;
  logic [3:0] nib_out;
  logic       nib_valid;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [7:0] spike_count;

  adex_spike_isi_monitor #(.TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .enable_core(enable_core), .spike_in(spike_in),
    .rd_ack(rd_ack), .nib_out(nib_out), .nib_valid(nib_valid),
    .fifo_level(fifo_level), .overflow(overflow), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_on = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: time is the number of enabled cycles since reset; an
  // interval is the difference of the times of two spike events. Words wait
  // in a queue; acks are counted against the head word.
  int q[$];
  int m_time, m_last, m_acks, m_cnt;
  bit m_ovf, m_sp, m_ap;

  task automatic model_step();
    bit a_ev, s_ev;
    int isi;
    if (reset) begin
      q.delete();
      m_time = 0; m_last = 1; m_acks = 0; m_cnt = 0;
      m_ovf = 0; m_sp = 0; m_ap = 0;
    end else begin
      a_ev = rd_ack && !m_ap;
      s_ev = spike_in && !m_sp && enable_core;
      m_sp = spike_in;
      m_ap = rd_ack;
      if (a_ev && q.size() > 0) begin
        if (m_acks == NIBS - 1) begin
          void'(q.pop_front());
          m_acks = 0;
        end else begin
          m_acks++;
        end
      end
      if (enable_core) m_time++;
      if (s_ev) begin
        if (m_cnt < 255) m_cnt++;
        isi = m_time - m_last;
        if (isi > ISI_CAP) isi = ISI_CAP;
        m_last = m_time;
        if (q.size() < FIFO_DEPTH) q.push_back(isi);
        else m_ovf = 1;
      end
    end
  endtask

  function automatic logic [3:0] model_nib();
    int w;
    w = q[0];
    return 4'((w >> (4 * (NIBS - 1 - m_acks))) & 15);
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Continuous comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      check_val("level", fifo_level, q.size());
      check_val("overflow", overflow, m_ovf);
      check_val("spike_count", spike_count, m_cnt);
      if (q.size() == 0) check_val("valid_when_empty", nib_valid, 0);
      else if (nib_valid) check_val("nibble", nib_out, model_nib());
    end
  end

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    rd_ack = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic spike_pulse();
    spike_in = 1'b1;
    @(negedge clk);
    spike_in = 1'b0;
    @(negedge clk);
  endtask

  // Wait (bounded) for a valid nibble, check it, then give one ack edge.
  task automatic ack_nib(input string tag, input logic [3:0] exp_nib, input bit use_model);
    int n;
    logic [3:0] e;
    n = 0;
    while (!nib_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_valid"}, nib_valid, 1);
    e = (use_model && q.size() > 0) ? model_nib() : exp_nib;
    check_val(tag, nib_out, e);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (q.size() > 0 && g < 64) begin
      ack_nib(tag, 4'h0, 1'b1);
      g++;
    end
    check_val({tag, "_empty"}, q.size() == 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // T1: reset with spike_in and rd_ack high, core disabled
    enable_core = 1'b0; spike_in = 1'b1; rd_ack = 1'b1; reset = 1'b1;
    @(negedge clk);
    mon_on = 1'b1;
    @(negedge clk);
    check_val("t1_nib_out", nib_out, 0);
    check_val("t1_nib_valid", nib_valid, 0);
    check_val("t1_level", fifo_level, 0);
    check_val("t1_overflow", overflow, 0);
    check_val("t1_count", spike_count, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    enable_core = 1'b1;
    repeat (3) @(negedge clk);
    check_val("t1_no_push_level", fifo_level, 0);
    check_val("t1_no_push_count", spike_count, 0);
    spike_in = 1'b0; rd_ack = 1'b0;

    // T2: intervals 10 and 25 from reset release
    enable_core = 1'b1;
    do_reset(2);
    repeat (10) @(negedge clk);
    spike_in = 1'b1;
    @(negedge clk);
    spike_in = 1'b0;
    repeat (24) @(negedge clk);
    spike_in = 1'b1;
    @(negedge clk);
    spike_in = 1'b0;
    @(negedge clk);
    check_val("t2_level", fifo_level, 2);
    check_val("t2_count", spike_count, 2);

    // T3: readout of 10 then 25
    ack_nib("t3_w0_n2", 4'h0, 1'b0);
    ack_nib("t3_w0_n1", 4'h0, 1'b0);
    ack_nib("t3_w0_n0", 4'hA, 1'b0);
    check_val("t3_level_after_pop", fifo_level, 1);
    ack_nib("t3_w1_n2", 4'h0, 1'b0);
    ack_nib("t3_w1_n1", 4'h1, 1'b0);
    ack_nib("t3_w1_n0", 4'h9, 1'b0);
    check_val("t3_level_end", fifo_level, 0);

    // T4: five spikes into a four-entry FIFO
    do_reset(2);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      repeat (i + 1) @(negedge clk);
      spike_pulse();
    end
    check_val("t4_level", fifo_level, 4);
    check_val("t4_overflow", overflow, 1);
    check_val("t4_count", spike_count, 5);
    drain("t4_drain");
    check_val("t4_overflow_sticky", overflow, 1);

    // T5: saturation, then gated cycles not counted
    do_reset(2);
    repeat (5000) @(negedge clk);
    spike_pulse();
    repeat (8) @(negedge clk);
    enable_core = 1'b0;
    for (int i = 0; i < 20; i++) begin
      spike_in = (i % 4) >= 2;
      @(negedge clk);
    end
    spike_in = 1'b0;
    enable_core = 1'b1;
    repeat (5) @(negedge clk);
    spike_in = 1'b1;
    @(negedge clk);
    spike_in = 1'b0;
    @(negedge clk);
    check_val("t5_count", spike_count, 2);
    ack_nib("t5_sat_n2", 4'hF, 1'b0);
    ack_nib("t5_sat_n1", 4'hF, 1'b0);
    ack_nib("t5_sat_n0", 4'hF, 1'b0);
    ack_nib("t5_gap_n2", 4'h0, 1'b0);
    ack_nib("t5_gap_n1", 4'h0, 1'b0);
    ack_nib("t5_gap_n0", 4'hF, 1'b0);

    // T6: reset mid-word, then push and pop together at full
    do_reset(2);
    repeat (3) spike_pulse();
    ack_nib("t6_first", 4'h0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("t6_valid_after_reset", nib_valid, 0);
    check_val("t6_level_after_reset", fifo_level, 0);
    repeat (4) spike_pulse();
    check_val("t6_full", fifo_level, 4);
    ack_nib("t6_n2", 4'h0, 1'b1);
    ack_nib("t6_n1", 4'h0, 1'b1);
    check_val("t6_valid_before_pp", nib_valid, 1);
    spike_in = 1'b1;
    rd_ack = 1'b1;
    @(negedge clk);
    spike_in = 1'b0;
    rd_ack = 1'b0;
    check_val("t6_pp_level", fifo_level, 4);
    check_val("t6_pp_overflow", overflow, 0);
    @(negedge clk);
    drain("t6_drain");

    // Random phase: busy spiking, then sparse spiking, occasional resets
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      bit a;
      enable_core = ($urandom_range(9) != 0);
      spike_in = (i < 1500) ? ($urandom_range(3) == 0) : ($urandom_range(31) == 0);
      a = $urandom_range(1);
      if (!rd_ack && !nib_valid) a = 1'b0;
      rd_ack = a;
      reset = ($urandom_range(499) == 0);
      if (reset) rd_ack = 1'b0;
      @(negedge clk);
    end
    reset = 1'b0;
    spike_in = 1'b0;
    rd_ack = 1'b0;
    @(negedge clk);
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
